// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the fetch/data memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_gnt_e   : which requester owns the in-flight transaction
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_gnt_e;

  localparam int MAX_DATA_STREAK_DEF = 4;

  // Fetches carry no size code of their own; they always move a full word.
  localparam logic [2:0] FETCH_SIZE = 3'd2;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (I) and
// data access (D), with at most one transaction in flight.
//   clk, rst                      : clock, synchronous active-high reset
//   iReq/iAddr/iKill              : fetch request, address, redirect kill
//   iRdata/iValid                 : fetch data, one-cycle completion pulse
//   dReq/dWen/dAddr/dWdata/dSize  : data request fields
//   dRdata/dValid                 : load data, one-cycle completion pulse
//   memReq/memWen/memAddr/memWdata/memSize : memory request (held until memReady)
//   memReady/memRvalid/memRdata   : memory accept, read data return
//   stall                         : some requester is still waiting
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  input  logic        iKill,
  output logic [31:0] iRdata,
  output logic        iValid,
  input  logic        dReq,
  input  logic        dWen,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [2:0]  dSize,
  output logic [31:0] dRdata,
  output logic        dValid,
  output logic        memReq,
  output logic        memWen,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [2:0]  memSize,
  input  logic        memReady,
  input  logic        memRvalid,
  input  logic [31:0] memRdata,
  output logic        stall
);

  // +2 keeps the counter at least one bit wide even for MAX_DATA_STREAK=0.
  localparam int SW = $clog2(MAX_DATA_STREAK + 2);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);

  arb_state_e    state_q,  state_d;
  arb_gnt_e      gnt_q,    gnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0]   addr_q,   addr_d;
  logic [31:0]   wdata_q,  wdata_d;
  logic [2:0]    size_q,   size_d;
  logic          wen_q,    wen_d;
  logic          mreq_q,   mreq_d;
  logic [31:0]   irdata_q, irdata_d;
  logic [31:0]   drdata_q, drdata_d;
  logic          ivld_q,   ivld_d;
  logic          dvld_q,   dvld_d;
  logic          kill_q,   kill_d;

  logic is_i, i_dead;
  assign is_i   = (gnt_q == GNT_I);
  // A fetch is dead once a kill has been seen at any point since its grant.
  assign i_dead = is_i & (kill_q | iKill);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    wen_d    = wen_q;
    mreq_d   = mreq_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    ivld_d   = 1'b0;
    dvld_d   = 1'b0;
    kill_d   = kill_q;
    unique case (state_q)
      IDLE: begin
        if (iReq || dReq) begin
          // Data wins unless fetch has been starved for a full streak.
          if (dReq && !(iReq && streak_q == SMAX)) begin
            gnt_d    = GNT_D;
            addr_d   = dAddr;
            wdata_d  = dWdata;
            size_d   = dSize;
            wen_d    = dWen;
            streak_d = (streak_q == SMAX) ? streak_q : streak_q + 1'b1;
          end else begin
            gnt_d    = GNT_I;
            addr_d   = iAddr;
            wdata_d  = '0;
            size_d   = FETCH_SIZE;
            wen_d    = 1'b0;
            streak_d = '0;
          end
          kill_d  = 1'b0;
          mreq_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        kill_d = i_dead;
        if (memReady) begin
          mreq_d = 1'b0;
          if (wen_q) begin
            state_d = DONE;
            dvld_d  = !is_i;
            ivld_d  = is_i && !i_dead;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        kill_d = i_dead;
        if (memRvalid) begin
          state_d = DONE;
          if (!is_i) begin
            drdata_d = memRdata;
            dvld_d   = 1'b1;
          end else if (!i_dead) begin
            irdata_d = memRdata;
            ivld_d   = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= GNT_I;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      wen_q    <= 1'b0;
      mreq_q   <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
      ivld_q   <= 1'b0;
      dvld_q   <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      wen_q    <= wen_d;
      mreq_q   <= mreq_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      ivld_q   <= ivld_d;
      dvld_q   <= dvld_d;
      kill_q   <= kill_d;
    end
  end

  assign memReq   = mreq_q;
  assign memWen   = wen_q;
  assign memAddr  = addr_q;
  assign memWdata = wdata_q;
  assign memSize  = size_q;
  assign iRdata   = irdata_q;
  assign dRdata   = drdata_q;
  // A kill landing in the DONE cycle itself can only be honoured by masking.
  assign iValid   = ivld_q & ~iKill;
  assign dValid   = dvld_q;
  assign stall    = (iReq & ~iValid) | (dReq & ~dValid);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DATA_STREAK, default 4, the number of consecutive data grants allowed while a fetch is pending.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- iReq  in  1  fetch request.
- iAddr  in  32  fetch address.
- iKill  in  1  discard the current fetch (wrong-branch redirect).
- iRdata  out  32  fetch data.
- iValid  out  1  fetch complete, one-cycle pulse.
- dReq  in  1  data request.
- dWen  in  1  data write.
- dAddr  in  32  data address.
- dWdata  in  32  store data.
- dSize  in  3  load/store size code.
- dRdata  out  32  load data.
- dValid  out  1  data complete, one-cycle pulse.
- memReq  out  1  memory request.
- memWen  out  1  memory write.
- memAddr  out  32  memory address.
- memWdata  out  32  memory write data.
- memSize  out  3  memory size code.
- memReady  in  1  memory accepts the request.
- memRvalid  in  1  memory read data valid.
- memRdata  in  32  memory read data.
- stall  out  1  a request is still outstanding.

Function
REQ-003 SHALL share one memory port between fetch and data, with at most one transaction outstanding.
REQ-004 SHALL implement FSM states IDLE, REQ, WAIT and DONE.
REQ-005 IDLE: if iReq or dReq is high, SHALL register the grant (I or D) and the winner's address, wdata, size and wen, then go to REQ. Otherwise SHALL stay in IDLE.
REQ-006 Priority: D SHALL win unless iReq is high and streak == MAX_DATA_STREAK, in which case I SHALL win.
REQ-007 The streak counter SHALL increment, saturating at MAX_DATA_STREAK, on each D grant, and SHALL clear on each I grant.
REQ-008 REQ: memReq SHALL be 1 and all mem* outputs SHALL come from the registered fields and stay stable until memReady. memReq SHALL NOT be retracted before memReady, even if the requester drops its request.
REQ-009 REQ with memReady=1: a read SHALL go to WAIT; a write SHALL go to DONE.
REQ-010 WAIT: memReq SHALL be 0. On memRvalid, SHALL capture memRdata into the granted requester's rdata register and go to DONE.
REQ-011 DONE: SHALL pulse the granted requester's valid for exactly one cycle, then go to IDLE. In the same DONE cycle it SHALL NOT start a new arbitration.
REQ-012 Minimum latency SHALL be: request sampled in cycle N, memReq in N+1; a write completes with valid in N+2; a read with memRvalid in N+2 completes with valid in N+3.
REQ-013 iKill asserted while an I transaction is in REQ, WAIT or DONE:
- the transaction SHALL complete on the memory side;
- iValid SHALL be suppressed;
- iRdata SHALL remain unchanged.
REQ-014 iKill SHALL have no effect on D transactions.
REQ-015 memRvalid received outside WAIT SHALL be ignored.
REQ-016 stall SHALL equal (iReq & ~iValid) | (dReq & ~dValid), combinationally.
REQ-017 Requesters SHALL hold req and address stable until their valid; holding them is a requester obligation and SHALL NOT be checked by the block.
REQ-018 When iReq and dReq are both high, the loser SHALL be served in the next IDLE arbitration without needing to re-request.

Reset
REQ-019 On rst, the FSM SHALL go to IDLE and streak SHALL clear. memReq, memWen, iValid and dValid SHALL be 0. iRdata, dRdata, memAddr, memWdata and memSize SHALL be 0.
REQ-020 rst mid-transaction SHALL abandon it: memReq SHALL be 0 from the next cycle, no valid pulse SHALL be produced, and any late memRvalid SHALL be ignored.

Structure
REQ-021 Package mem_arb_pkg SHALL hold the state enum (IDLE/REQ/WAIT/DONE), the grant enum (GNT_I/GNT_D) and the default for MAX_DATA_STREAK.
REQ-022 SHALL be a single module with no sub-module; the streak counter SHALL be inline.

Verification
REQ-023 Fetch only: iReq=1, iAddr=0x100, memReady=1, read data 0xDEADBEEF one cycle later -> memReq in N+1 with memAddr=0x100, iValid=1 with iRdata=0xDEADBEEF in N+3, stall=0 in N+4.
REQ-024 Simultaneous requests: iReq and dReq (load, dAddr=0x2000) in the same cycle -> D granted first, I granted in the next IDLE, iValid after dValid.
REQ-025 Starvation: dReq held high for 6 back-to-back loads with iReq high, MAX_DATA_STREAK=4 -> grant order D,D,D,D,I,D,D.
REQ-026 Store: dWen=1, dAddr=0x40, dWdata=0x55, dSize=2, memReady held 0 for 3 cycles -> memReq stays high with stable fields; dValid 1 cycle after memReady; no memRvalid needed.
REQ-027 Kill: iKill pulsed while an I transaction is in WAIT -> memRvalid consumed, iValid never asserted, iRdata unchanged.
REQ-028 Reset mid-read: rst asserted in WAIT, memRvalid arrives 2 cycles later -> all outputs at reset values, no valid pulse, FSM in IDLE.
